// File: rtl/gcd_controller_pkg.sv
// Shared definitions for the GCD controller: FSM state encoding and mux select codes.
package gcd_controller_pkg;

    localparam int unsigned DataW = 16;

    // SUB operand mux codes
    localparam logic MuxA = 1'b0;
    localparam logic MuxB = 1'b1;

    // PIPO input bus mux codes
    localparam logic BusSub = 1'b0;
    localparam logic BusIn  = 1'b1;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StLdA  = 3'd1,
        StLdB  = 3'd2,
        StCmp  = 3'd3,
        StSubA = 3'd4,
        StSubB = 3'd5,
        StDone = 3'd6,
        StErr  = 3'd7
    } state_e;

endpackage

// File: rtl/gcd_controller_iter_cnt.sv
// Saturating iteration counter with synchronous clear and limit detect.
module gcd_controller_iter_cnt #(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned MAX_ITER = 65535
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_limit
);

    logic [CNT_W-1:0] r_cnt;

    assign o_limit = (r_cnt == CNT_W'(MAX_ITER));
    assign o_cnt   = r_cnt;

    // Limit gate keeps the count from ever wrapping
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !o_limit) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/gcd_controller.sv
// Moore FSM sequencing the subtract-and-compare GCD datapath: load A, load B,
// then alternate compare/subtract until equal, the iteration limit, or bad flags.
module gcd_controller
    import gcd_controller_pkg::*;
#(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned MAX_ITER = 65535
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic             i_lt,
    input  logic             i_gt,
    input  logic             i_eq,
    output logic             o_lda,
    output logic             o_ldb,
    output logic             o_sel1,
    output logic             o_sel2,
    output logic             o_sel_in,
    output logic             o_a_req,
    output logic             o_b_req,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    output logic [CNT_W-1:0] o_iter_cnt
);

    state_e r_state;
    state_e w_state_next;
    logic   w_cnt_clr;
    logic   w_cnt_inc;
    logic   w_limit;

    gcd_controller_iter_cnt #(
        .CNT_W    (CNT_W),
        .MAX_ITER (MAX_ITER)
    ) u_iter_cnt (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clr   (w_cnt_clr),
        .i_inc   (w_cnt_inc),
        .o_cnt   (o_iter_cnt),
        .o_limit (w_limit)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: if (i_start) w_state_next = StLdA;
            StLdA:  w_state_next = StLdB;
            StLdB:  w_state_next = StCmp;
            StCmp: begin
                // Exactly one flag must be set; eq wins over the limit
                case ({i_lt, i_gt, i_eq})
                    3'b001:  w_state_next = StDone;
                    3'b010:  w_state_next = w_limit ? StErr : StSubA;
                    3'b100:  w_state_next = w_limit ? StErr : StSubB;
                    default: w_state_next = StErr;
                endcase
            end
            StSubA: w_state_next = StCmp;
            StSubB: w_state_next = StCmp;
            StDone: w_state_next = StIdle;
            StErr:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
        if (i_abort) begin
            w_state_next = StIdle;
        end
    end

    assign w_cnt_clr = (r_state == StIdle) && i_start && !i_abort;
    assign w_cnt_inc = (r_state == StSubA) || (r_state == StSubB);

    always_comb begin
        o_lda    = 1'b0;
        o_ldb    = 1'b0;
        o_sel1   = MuxA;
        o_sel2   = MuxA;
        o_sel_in = BusSub;
        o_a_req  = 1'b0;
        o_b_req  = 1'b0;
        o_busy   = 1'b0;
        o_done   = 1'b0;
        o_err    = 1'b0;
        unique case (r_state)
            StLdA: begin
                o_lda    = 1'b1;
                o_sel_in = BusIn;
                o_a_req  = 1'b1;
                o_busy   = 1'b1;
            end
            StLdB: begin
                o_ldb    = 1'b1;
                o_sel_in = BusIn;
                o_b_req  = 1'b1;
                o_busy   = 1'b1;
            end
            StCmp: o_busy = 1'b1;
            StSubA: begin
                o_lda  = 1'b1;
                o_sel1 = MuxA;
                o_sel2 = MuxB;
                o_busy = 1'b1;
            end
            StSubB: begin
                o_ldb  = 1'b1;
                o_sel1 = MuxB;
                o_sel2 = MuxA;
                o_busy = 1'b1;
            end
            StDone: o_done = 1'b1;
            StErr:  o_err  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_gcd_controller.sv
// Directed bench: controller plus behavioural subtract/compare datapath, two instances.
module tb_gcd_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, abort, m_start, s_start, s_force;
    int   checks = 0;
    int   errors = 0;

    // Main instance (default limit) and its datapath
    logic        m_lt, m_gt, m_eq, m_lda, m_ldb, m_sel1, m_sel2, m_selin;
    logic        m_areq, m_breq, m_busy, m_done, m_err;
    logic [15:0] m_cnt, m_a = '0, m_b = '0, m_opa, m_opb, m_din, m_x, m_y, m_bus;

    assign m_din = m_areq ? m_opa : (m_breq ? m_opb : 16'd0);
    assign m_x   = m_sel1 ? m_b : m_a;
    assign m_y   = m_sel2 ? m_b : m_a;
    assign m_bus = m_selin ? m_din : (m_x - m_y);
    assign m_lt  = m_a < m_b;
    assign m_gt  = m_a > m_b;
    assign m_eq  = m_a == m_b;
    always @(posedge clk) begin
        if (m_lda) m_a <= m_bus;
        if (m_ldb) m_b <= m_bus;
    end

    gcd_controller u_dut (
        .i_clk(clk), .i_rst(rst), .i_start(m_start), .i_abort(abort),
        .i_lt(m_lt), .i_gt(m_gt), .i_eq(m_eq),
        .o_lda(m_lda), .o_ldb(m_ldb), .o_sel1(m_sel1), .o_sel2(m_sel2), .o_sel_in(m_selin),
        .o_a_req(m_areq), .o_b_req(m_breq), .o_busy(m_busy), .o_done(m_done), .o_err(m_err),
        .o_iter_cnt(m_cnt)
    );

    // Small instance (limit 8) with flag override
    logic        s_lt, s_gt, s_eq, s_lda, s_ldb, s_sel1, s_sel2, s_selin;
    logic        s_areq, s_breq, s_busy, s_done, s_err;
    logic [15:0] s_cnt, s_a = '0, s_b = '0, s_opa, s_opb, s_din, s_x, s_y, s_bus;

    assign s_din = s_areq ? s_opa : (s_breq ? s_opb : 16'd0);
    assign s_x   = s_sel1 ? s_b : s_a;
    assign s_y   = s_sel2 ? s_b : s_a;
    assign s_bus = s_selin ? s_din : (s_x - s_y);
    assign s_lt  = s_force ? 1'b1 : (s_a < s_b);
    assign s_gt  = s_force ? 1'b1 : (s_a > s_b);
    assign s_eq  = s_force ? 1'b0 : (s_a == s_b);
    always @(posedge clk) begin
        if (s_lda) s_a <= s_bus;
        if (s_ldb) s_b <= s_bus;
    end

    gcd_controller #(.CNT_W(16), .MAX_ITER(8)) u_small (
        .i_clk(clk), .i_rst(rst), .i_start(s_start), .i_abort(abort),
        .i_lt(s_lt), .i_gt(s_gt), .i_eq(s_eq),
        .o_lda(s_lda), .o_ldb(s_ldb), .o_sel1(s_sel1), .o_sel2(s_sel2), .o_sel_in(s_selin),
        .o_a_req(s_areq), .o_b_req(s_breq), .o_busy(s_busy), .o_done(s_done), .o_err(s_err),
        .o_iter_cnt(s_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start main run; n counts cycles after start is sampled (n=1 is LD_A)
    task automatic run_main(input logic [15:0] a, input logic [15:0] b, input int pulse_at,
                            output int n, output bit saw_done, output bit saw_err);
        m_opa = a;
        m_opb = b;
        m_start = 1'b1;
        tick();
        m_start = 1'b0;
        n = 1;
        saw_done = 1'b0;
        saw_err = 1'b0;
        while (n < 300) begin
            if (m_err) saw_err = 1'b1;
            if (m_done) begin
                saw_done = 1'b1;
                break;
            end
            if (n == pulse_at) m_start = 1'b1;
            tick();
            m_start = 1'b0;
            n++;
        end
    endtask

    int n;
    int sub_b;
    bit sd, se, bad;

    initial begin
        rst = 1'b1; abort = 1'b0; m_start = 1'b0; s_start = 1'b0; s_force = 1'b0;
        m_opa = '0; m_opb = '0; s_opa = '0; s_opb = '0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_outs", {m_lda, m_ldb, m_sel1, m_sel2, m_selin, m_areq, m_breq, m_busy,
                             m_done, m_err}, 0);
        check("reset_cnt", m_cnt, 0);
        check("reset_small_busy", s_busy, 0);

        // 48,18: four subtractions
        run_main(16'd48, 16'd18, 0, n, sd, se);
        check("g48_done", sd, 1);
        check("g48_lat", n, 12);
        check("g48_noerr", se, 0);
        check("g48_cnt", m_cnt, 4);
        check("g48_a", m_a, 6);
        check("g48_b", m_b, 6);
        tick();
        check("g48_pulse", m_done, 0);
        check("g48_hold", m_cnt, 4);

        // 7,7: per-cycle load enables
        m_opa = 16'd7; m_opb = 16'd7; m_start = 1'b1;
        tick();
        m_start = 1'b0;
        check("eq_c1", {m_lda, m_ldb, m_areq, m_breq, m_selin, m_busy}, 6'b101011);
        tick();
        check("eq_c2", {m_lda, m_ldb, m_areq, m_breq, m_selin, m_busy}, 6'b010111);
        tick();
        check("eq_c3", {m_lda, m_ldb, m_busy, m_done}, 4'b0010);
        tick();
        check("eq_c4", {m_lda, m_ldb, m_busy, m_done, m_err}, 5'b00010);
        check("eq_cnt", m_cnt, 0);
        tick();

        // Start pulsed in cycle 5 must be ignored
        run_main(16'd48, 16'd18, 5, n, sd, se);
        check("restart_lat", n, 12);
        check("restart_a", m_a, 6);
        check("restart_cnt", m_cnt, 4);
        tick();

        // Reset mid-run in cycle 6
        m_opa = 16'd48; m_opb = 16'd18; m_start = 1'b1;
        tick();
        m_start = 1'b0;
        for (int i = 2; i <= 6; i++) tick();
        check("pre_rst_busy", m_busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_outs", {m_lda, m_ldb, m_sel1, m_sel2, m_selin, m_areq, m_breq, m_busy,
                           m_done, m_err}, 0);
        check("rst_cnt", m_cnt, 0);
        run_main(16'd9, 16'd6, 0, n, sd, se);
        check("g9_lat", n, 8);
        check("g9_a", m_a, 3);
        check("g9_cnt", m_cnt, 2);
        tick();

        // Abort in the first SUB_A of 100,1
        m_opa = 16'd100; m_opb = 16'd1; m_start = 1'b1;
        tick();
        m_start = 1'b0;
        for (int i = 2; i <= 4; i++) tick();
        check("ab_suba", {m_lda, m_selin, m_sel1, m_sel2}, 4'b1001);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_busy", m_busy, 0);
        check("ab_cnt", m_cnt, 1);
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (m_done || m_err || m_busy) bad = 1'b1;
            tick();
        end
        check("ab_quiet", bad, 0);
        abort = 1'b1; m_start = 1'b1;
        tick();
        abort = 1'b0; m_start = 1'b0;
        check("ab_start_idle", {m_busy, m_areq}, 2'b00);
        check("ab_start_cnt", m_cnt, 1);

        // Zero operand hits the limit of 8 on the small instance
        s_opa = 16'd0; s_opb = 16'd5; s_start = 1'b1;
        tick();
        s_start = 1'b0;
        n = 1; sd = 1'b0; se = 1'b0; sub_b = 0;
        while (n < 200) begin
            if (s_done) sd = 1'b1;
            if (s_ldb && !s_selin) sub_b++;
            if (s_err) begin
                se = 1'b1;
                break;
            end
            tick();
            n++;
        end
        check("zero_err", se, 1);
        check("zero_nodone", sd, 0);
        check("zero_subs", sub_b, 8);
        check("zero_cnt", s_cnt, 8);
        check("zero_lat", n, 20);
        tick();

        // Invalid flags (lt and gt both high) in CMP
        s_force = 1'b1; s_opa = 16'd3; s_opb = 16'd4; s_start = 1'b1;
        tick();
        s_start = 1'b0;
        tick();
        tick();
        check("bad_cmp", {s_busy, s_lda, s_ldb}, 3'b100);
        tick();
        check("bad_err", {s_err, s_done, s_lda, s_ldb}, 4'b1000);
        s_force = 1'b0;
        tick();
        check("bad_idle", {s_err, s_busy}, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
